k2_program_loader: RTL and testbench
====================================

K2_PROGRAM_LOADER -- requirements
Module: k2_program_loader

Interface
REQ-001 Parameter: Depth, 16, number of 10-bit program memory entries; address width 4.
REQ-002 Parameter: InstBits, 10, instruction width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 load_req  in  1  one-cycle request to start a program download.
REQ-007 rx_valid  in  1  one-cycle pulse; UART receiver has a byte on rx_data.
REQ-008 rx_correct  in  1  parity OK for the byte flagged by rx_valid.
REQ-009 rx_data  in  8  received byte.
REQ-010 tx_busy  in  1  UART transmitter is sending; tx_start is not accepted.
REQ-011 tx_start  out  1  one-cycle pulse to send tx_data.
REQ-012 tx_data  out  8  acknowledge byte: 0x06 OK, 0x15 fail.
REQ-013 ProgramAddress  in  4  processor fetch address.
REQ-014 instruction_data  out  10  memory[ProgramAddress], combinational read.
REQ-015 proc_rst_n  out  1  active-low hold-in-reset for the K2 processor.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on tx_start of a successful load.
REQ-018 error  out  1  sticky failure flag.

Function
REQ-019 States SHALL be IDLE, HDR, CNT, HI, LO, SUM, ACK.
REQ-020 IDLE: on load_req, the block SHALL go to HDR, clear all entries to 0 on that edge, drive proc_rst_n=0 from the next cycle, clear error, zero the checksum accumulator and write index.
REQ-021 IDLE SHALL ignore rx_valid; load_req together with rx_valid in IDLE SHALL start the load and discard the byte.
REQ-022 load_req outside IDLE SHALL be ignored.
REQ-023 States HDR through SUM SHALL advance only on cycles with rx_valid=1.
REQ-024 HDR: byte 0xA5 SHALL go to CNT; any other byte SHALL be a failure.
REQ-025 CNT: byte N in 1..16 SHALL be latched, then go to HI; N=0 or N>16 SHALL be a failure.
REQ-026 HI: bits [7:2] SHALL be 0, else failure; bits [1:0] SHALL be latched as inst[9:8]; byte added to the checksum; go to LO.
REQ-027 LO: memory[index] SHALL be written with {hi[1:0], byte} on this edge; byte added to the checksum; index increments; go to HI if index+1<N, else SUM.
REQ-028 Checksum SHALL be the 8-bit modulo-256 sum of all HI and LO bytes; CNT and HDR are excluded.
REQ-029 SUM: byte equal to the checksum SHALL be success; otherwise failure.
REQ-030 Any rx_valid with rx_correct=0 in HDR..SUM SHALL be a failure, regardless of byte value.
REQ-031 Failure SHALL set error=1, select tx_data=0x15 and go to ACK; success SHALL select 0x06 and go to ACK.
REQ-032 ACK SHALL ignore rx_valid and SHALL wait while tx_busy=1.
REQ-033 On the first ACK cycle with tx_busy=0, tx_start SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-034 On success, done SHALL pulse with tx_start, and proc_rst_n SHALL return to 1 on the following cycle.
REQ-035 On failure, proc_rst_n SHALL stay 0 until a later load succeeds.
REQ-036 Entries already written before a failure SHALL keep their values; entries at index>=N SHALL stay 0.
REQ-037 instruction_data SHALL always reflect the current memory contents, including during a load.

Reset
REQ-038 On rst=1, regardless of clock: state=IDLE, all entries=0, proc_rst_n=1, busy=0, done=0, error=0, tx_start=0, tx_data=0x00, checksum=0, index=0.
REQ-039 Reset asserted mid-load SHALL abort the load with no acknowledge sent.

Verification
REQ-040 Bench: load_req, then bytes A5,02,03,FF,00,15,17 with tx_busy=0 -> mem[0]=0x3FF, mem[1]=0x015, mem[2..15]=0; tx_data=0x06 with one tx_start and done pulse; proc_rst_n=1 after ACK; error=0.
REQ-041 Bench: A5,01,04,00,04 -> HI byte 0x04 fails; tx_data=0x15; error=1; proc_rst_n stays 0; mem all 0.
REQ-042 Bench: A5,01,00,2A,00 -> bad checksum; tx_data=0x15; mem[0]=0x02A retained; error=1.
REQ-043 Bench: tx_busy=1 held 5 cycles at ACK -> no tx_start until tx_busy falls, then exactly one pulse.
REQ-044 Bench: rx_correct=0 on the CNT byte -> failure 0x15; load_req while busy ignored; N=0x11 -> failure.
REQ-045 Bench: rst pulsed during LO -> all outputs at reset values, mem=0, next load_req starts a clean load.

Source files
------------

// File: rtl/k2_program_loader.sv
// Downloads a checksummed program over a UART byte stream into the K2
// instruction memory, holding the processor in reset until a load succeeds.
module k2_program_loader #(
  parameter int Depth    = 16,
  parameter int InstBits = 10,
  localparam int AddrBits = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic                rx_valid,
  input  logic                rx_correct,
  input  logic [7:0]          rx_data,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic [AddrBits-1:0] ProgramAddress,
  output logic [InstBits-1:0] instruction_data,
  output logic                proc_rst_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          state_dbg
);

  // Handshake: rx_valid is a one-cycle pulse, consumed only in HDR..SUM.
  // tx_start is a one-cycle pulse issued only after a cycle with tx_busy=0.
  typedef enum logic [2:0] {IDLE, HDR, CNT, HI, LO, SUM, ACK} state_t;

  localparam logic [7:0] HeaderByte = 8'hA5;
  localparam logic [7:0] AckOk      = 8'h06;
  localparam logic [7:0] AckFail    = 8'h15;
  localparam logic [7:0] DepthByte  = 8'(Depth);

  state_t                state;
  logic [InstBits-1:0]   mem [Depth];
  logic [7:0]            checksum;
  logic [7:0]            count;
  logic [AddrBits-1:0]   index;
  logic [1:0]            hi_bits;
  logic [7:0]            idx_next;
  logic                  byte_bad;

  assign instruction_data = mem[ProgramAddress];
  assign busy             = (state != IDLE);
  assign state_dbg        = state;
  assign idx_next         = 8'(index) + 8'd1;

  always_comb begin
    byte_bad = 1'b0;
    if (!rx_correct) begin
      byte_bad = 1'b1;
    end else begin
      case (state)
        HDR:     byte_bad = (rx_data != HeaderByte);
        CNT:     byte_bad = (rx_data == 8'd0) || (rx_data > DepthByte);
        HI:      byte_bad = (rx_data[7:2] != 6'd0);
        SUM:     byte_bad = (rx_data != checksum);
        default: byte_bad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      proc_rst_n <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      checksum   <= 8'h00;
      count      <= 8'h00;
      index      <= '0;
      hi_bits    <= 2'b00;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      // Processor is released the cycle after the success pulse.
      if (done) proc_rst_n <= 1'b1;
      case (state)
        IDLE: begin
          if (load_req) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
            proc_rst_n <= 1'b0;
            error      <= 1'b0;
            checksum   <= 8'h00;
            index      <= '0;
            state      <= HDR;
          end
        end
        HDR, CNT, HI, LO, SUM: begin
          if (rx_valid) begin
            if (byte_bad) begin
              error   <= 1'b1;
              tx_data <= AckFail;
              state   <= ACK;
            end else begin
              case (state)
                HDR: state <= CNT;
                CNT: begin
                  count <= rx_data;
                  state <= HI;
                end
                HI: begin
                  hi_bits  <= rx_data[1:0];
                  checksum <= checksum + rx_data;
                  state    <= LO;
                end
                LO: begin
                  mem[index] <= InstBits'({hi_bits, rx_data});
                  checksum   <= checksum + rx_data;
                  index      <= index + AddrBits'(1);
                  state      <= (idx_next < count) ? HI : SUM;
                end
                default: begin
                  tx_data <= AckOk;
                  state   <= ACK;
                end
              endcase
            end
          end
        end
        ACK: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            done     <= ~error;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed bench for k2_program_loader: a byte-stream parsing model predicts
// memory, acknowledge byte and flags; a monitor compares every cycle.
module tb_k2_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req;
  logic       rx_valid;
  logic       rx_correct;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] ProgramAddress;
  logic [9:0] instruction_data;
  logic       proc_rst_n;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state_dbg;

  k2_program_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .rx_valid(rx_valid),
    .rx_correct(rx_correct), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .ProgramAddress(ProgramAddress),
    .instruction_data(instruction_data), .proc_rst_n(proc_rst_n),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [8:0] stim_q[$];          // {rx_correct, rx_data}
  logic [9:0] model_mem [16];
  logic       model_err;
  logic       model_prn;
  logic [9:0] pend_mem [16];
  logic       pend_err;
  logic       pend_prn;
  logic [7:0] pend_ack;

  int   tx_count    = 0;
  logic mon_en      = 1'b0;
  logic txb_at_edge = 1'b0;
  logic done_seen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model: parse the whole byte stream ----------------
  function automatic logic [8:0] ent(int p);
    if (p < stim_q.size()) return stim_q[p];
    return 9'h000;
  endfunction

  task automatic model_parse();
    logic       fail;
    logic [7:0] sum;
    logic [8:0] h, l, s;
    int         n;
    for (int i = 0; i < 16; i++) pend_mem[i] = '0;
    fail = 1'b0;
    sum  = 8'h00;
    n    = 0;
    if (!ent(0)[8] || ent(0)[7:0] != 8'hA5) fail = 1'b1;
    else if (!ent(1)[8] || ent(1)[7:0] == 8'd0 || ent(1)[7:0] > 8'd16) fail = 1'b1;
    else n = int'(ent(1)[7:0]);
    for (int k = 0; k < n && !fail; k++) begin
      h = ent(2 + 2 * k);
      l = ent(3 + 2 * k);
      if (!h[8] || h[7:2] != 6'd0 || !l[8]) fail = 1'b1;
      else begin
        pend_mem[k] = {h[1:0], l[7:0]};
        sum = sum + h[7:0] + l[7:0];
      end
    end
    if (!fail) begin
      s = ent(2 + 2 * n);
      if (!s[8] || s[7:0] != sum) fail = 1'b1;
    end
    pend_err = fail;
    pend_prn = !fail;
    pend_ack = fail ? 8'h15 : 8'h06;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) txb_at_edge <= tx_busy;

  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en && !rst) begin
      if (done_seen) begin
        check("prn_after_done", proc_rst_n, 1);
        done_seen = 1'b0;
      end
      if (tx_start) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got tx_data %0h expected no pulse", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e);
          check("done_with_start", done, e == 8'h06);
          check("prn_low_at_done", proc_rst_n, 0);
          check("tx_busy_before_start", txb_at_edge, 0);
          if (e == 8'h06) done_seen = 1'b1;
        end
      end else begin
        check("done_idle", done, 0);
      end
      if (!busy && !done) begin
        check("error", error, model_err);
        check("proc_rst_n", proc_rst_n, model_prn);
        check("inst_mem", instruction_data, model_mem[ProgramAddress]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [8:0] b);
    rx_valid   = 1'b1;
    rx_correct = b[8];
    rx_data    = b[7:0];
    tick();
    rx_valid   = 1'b0;
    rx_correct = 1'b0;
    rx_data    = $urandom_range(0, 255);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check_mem_all(input string name);
    for (int a = 0; a < 16; a++) begin
      ProgramAddress = a[3:0];
      #1;
      check(name, instruction_data, model_mem[a]);
    end
    ProgramAddress = 4'd0;
  endtask

  task automatic run_load(input int lr_at, input bit busy_hold, input bit rx_with_req);
    int start_cnt;
    int w;
    model_parse();
    start_cnt = tx_count;
    load_req  = 1'b1;
    if (rx_with_req) begin
      rx_valid   = 1'b1;
      rx_correct = 1'b1;
      rx_data    = 8'h00;
    end
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = pend_mem[i];
    model_err = pend_err;
    model_prn = pend_prn;
    exp_q.push_back(pend_ack);
    check("prn_low_in_load", proc_rst_n, 0);
    check("busy_in_load", busy, 1);
    check("error_cleared", error, 0);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == lr_at) begin
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
      end
      if (busy_hold && i == stim_q.size() - 1) tx_busy = 1'b1;
      send_byte(stim_q[i]);
    end
    if (busy_hold) begin
      repeat (5) tick();
      check("no_tx_start_while_busy", tx_count, start_cnt);
      check("busy_held_in_ack", busy, 1);
      tx_busy = 1'b0;
    end
    w = 0;
    while (busy && w < 300) begin
      tick();
      w++;
    end
    if (busy) check("load_timeout", busy, 0);
    repeat (3) tick();
    check("one_tx_start", tx_count - start_cnt, 1);
    check_mem_all("mem_after_load");
  endtask

  task automatic set_stim40();
    stim_q = {9'h1A5, 9'h102, 9'h103, 9'h1FF, 9'h100, 9'h115, 9'h117};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_correct = 1'b0;
    rx_data = 8'h00; tx_busy = 1'b0; ProgramAddress = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_err = 1'b0;
    model_prn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_prn", proc_rst_n, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_inst", instruction_data, 10'h000);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Good two-entry load.
    set_stim40();
    run_load(-1, 1'b0, 1'b0);
    ProgramAddress = 4'd0; #1; check("lit40_mem0", instruction_data, 10'h3FF);
    ProgramAddress = 4'd1; #1; check("lit40_mem1", instruction_data, 10'h015);
    ProgramAddress = 4'd2; #1; check("lit40_mem2", instruction_data, 10'h000);
    ProgramAddress = 4'd0;
    check("lit40_tx_data", tx_data, 8'h06);
    check("lit40_error", error, 0);
    check("lit40_prn", proc_rst_n, 1);

    // HI byte with upper bits set.
    stim_q = {9'h1A5, 9'h101, 9'h104, 9'h100, 9'h104};
    run_load(-1, 1'b0, 1'b0);
    check("lit41_tx_data", tx_data, 8'h15);
    check("lit41_error", error, 1);
    check("lit41_prn", proc_rst_n, 0);

    // Bad checksum; load_req arrives with a byte that must be discarded.
    stim_q = {9'h1A5, 9'h101, 9'h100, 9'h12A, 9'h100};
    run_load(-1, 1'b0, 1'b1);
    ProgramAddress = 4'd0; #1; check("lit42_mem0", instruction_data, 10'h02A);
    check("lit42_error", error, 1);
    check("lit42_prn", proc_rst_n, 0);

    // Transmitter busy at ACK.
    set_stim40();
    run_load(-1, 1'b1, 1'b0);
    check("lit43_prn", proc_rst_n, 1);

    // Parity error on the count byte.
    stim_q = {9'h1A5, 9'h002, 9'h103, 9'h1FF};
    run_load(-1, 1'b0, 1'b0);
    check("lit44a_error", error, 1);

    // Count one beyond depth.
    stim_q = {9'h1A5, 9'h111, 9'h100, 9'h100};
    run_load(-1, 1'b0, 1'b0);
    check("lit44b_tx_data", tx_data, 8'h15);

    // load_req mid-load must be ignored.
    stim_q = {9'h1A5, 9'h101, 9'h101, 9'h123, 9'h124};
    run_load(2, 1'b0, 1'b0);
    ProgramAddress = 4'd0; #1; check("lit_lr_mem0", instruction_data, 10'h123);
    check("lit_lr_error", error, 0);

    // Full depth, checksum wraps.
    stim_q = {9'h1A5, 9'h110};
    for (int i = 0; i < 16; i++) begin
      stim_q.push_back({1'b1, 6'd0, 2'(i)});
      stim_q.push_back({1'b1, 8'(i * 17)});
    end
    stim_q.push_back({1'b1, 8'hF8});   // 0+1+2+3 repeated x4 = 24, plus 17*120=2040 -> 2064 mod 256 = 0x10... see below
    begin
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + 8'(i % 4) + 8'(i * 17);
      stim_q[stim_q.size() - 1] = {1'b1, s};
    end
    run_load(-1, 1'b0, 1'b0);
    ProgramAddress = 4'd15; #1; check("lit_full_mem15", instruction_data, 10'h3FF);
    ProgramAddress = 4'd0;
    check("lit_full_error", error, 0);

    // Reset while in LO aborts without acknowledge.
    begin
      int cnt0;
      cnt0 = tx_count;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      send_byte(9'h1A5);
      send_byte(9'h102);
      send_byte(9'h103);
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      model_err = 1'b0;
      model_prn = 1'b1;
      rst = 1'b1;
      #2;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_prn", proc_rst_n, 1);
      check("mid_rst_error", error, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_tx_start", tx_start, 0);
      check("mid_rst_tx_data", tx_data, 8'h00);
      check_mem_all("mid_rst_mem");
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_no_ack", tx_count, cnt0);
      check("mid_rst_no_pending", exp_q.size(), 0);
    end
    set_stim40();
    run_load(-1, 1'b0, 1'b0);
    ProgramAddress = 4'd1; #1; check("lit_after_rst_mem1", instruction_data, 10'h015);
    ProgramAddress = 4'd0;

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
